// File: rtl/sweep_ctrl_pkg.sv
// Shared types and default sizes for the sweep controller and its counter core.
package sweep_ctrl_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/updown_core.sv
// Loadable up/down counter with synchronous reset; load wins over inc/dec.
module updown_core #(
  parameter int WIDTH = sweep_ctrl_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (inc)
      count <= count + 1'b1;
    else if (dec)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Sweep controller: walks the counter lo->hi once or ping-pongs between the
// latched bounds, holding each value for dwell+1 cycles.
module sweep_counter_ctrl
  import sweep_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               pingpong,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [DWELL_W-1:0] dwell,
  output logic [WIDTH-1:0]   count,
  output logic               step_up,
  output logic               step_down,
  output logic               busy,
  output logic               done,
  output logic               err
);

  sweep_state_t       state, state_n;
  logic [WIDTH-1:0]   lo_l, hi_l;
  logic [DWELL_W-1:0] dwell_l, timer;
  logic               pp_l;
  logic               load, finish, reject;

  // Stop is checked before any step so an abort never moves the count.
  always_comb begin
    state_n   = state;
    step_up   = 1'b0;
    step_down = 1'b0;
    load      = 1'b0;
    finish    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (lo <= hi) begin
            load    = 1'b1;
            state_n = UP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      UP: begin
        if (stop) begin
          state_n = IDLE;
        end else if (timer == '0) begin
          if (count < hi_l) begin
            step_up = 1'b1;
          end else if (!pp_l) begin
            state_n = IDLE;
            finish  = 1'b1;
          end else if (lo_l < hi_l) begin
            step_down = 1'b1;
            state_n   = DOWN;
          end
        end
      end
      DOWN: begin
        if (stop) begin
          state_n = IDLE;
        end else if (timer == '0) begin
          if (count > lo_l) begin
            step_down = 1'b1;
          end else begin
            step_up = 1'b1;
            state_n = UP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      lo_l    <= '0;
      hi_l    <= '0;
      dwell_l <= '0;
      pp_l    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= finish;
      err   <= reject;
      if (load) begin
        lo_l    <= lo;
        hi_l    <= hi;
        dwell_l <= dwell;
        pp_l    <= pingpong;
      end
    end
  end

  // The timer reloads whenever it expires, including the lo == hi ping-pong hold.
  always_ff @(posedge clk) begin
    if (reset)
      timer <= '0;
    else if (load)
      timer <= dwell;
    else if (state != IDLE && !stop) begin
      if (timer != '0)
        timer <= timer - 1'b1;
      else
        timer <= dwell_l;
    end
  end

  assign busy = (state != IDLE);

  updown_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .value (lo),
    .inc   (step_up),
    .dec   (step_down),
    .count (count)
  );

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
// Self-checking bench: scenario table with a closed-form sweep model feeding a scoreboard.
module tb_sweep_counter_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, pingpong;
  logic [3:0] lo, hi, dwell;
  logic [3:0] count;
  logic       step_up, step_down, busy, done, err;

  typedef struct {
    logic [3:0] count;
    bit         busy;
    bit         done;
    bit         err;
    bit         up;
    bit         dn;
  } exp_t;

  typedef struct {
    bit pp;
    int lo, hi, dwell;
    int cycles, stopAt, pokeAt;
    bit chain, resetAfter;
    int expFinal, expDones;
  } scen_t;

  exp_t  sbq[$];
  scen_t tbl[10];
  int    checkCount = 0;
  int    passCount  = 0;
  int    doneSeen;
  int    lastDutCount;
  logic [3:0] lastCount;

  sweep_counter_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .pingpong  (pingpong),
    .lo        (lo),
    .hi        (hi),
    .dwell     (dwell),
    .count     (count),
    .step_up   (step_up),
    .step_down (step_down),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic chk(input string name, input int k, input int act, input int expv);
    checkCount++;
    if (act == expv) passCount++;
    else $display("[TB] FAIL %s k=%0d actual=%0d expected=%0d", name, k, act, expv);
  endtask

  // Closed-form model of an uninterrupted sweep, k cycles after the start edge.
  function automatic exp_t baseAt(scen_t s, int k);
    exp_t e;
    int d1, span, p, m, mn, pos, posn, n;
    bit last;
    e = '{count: 4'd0, busy: 1'b0, done: 1'b0, err: 1'b0, up: 1'b0, dn: 1'b0};
    d1   = s.dwell + 1;
    span = s.hi - s.lo;
    p    = k / d1;
    last = ((k % d1) == d1 - 1);
    if (!s.pp) begin
      n = (span + 1) * d1;
      if (k < n) begin
        e.count = 4'(s.lo + p);
        e.busy  = 1'b1;
        e.up    = last && (p < span);
      end else begin
        e.count = 4'(s.hi);
        e.done  = (k == n);
      end
    end else if (span == 0) begin
      e.count = 4'(s.lo);
      e.busy  = 1'b1;
    end else begin
      m    = p % (2 * span);
      mn   = (p + 1) % (2 * span);
      pos  = (m  <= span) ? m  : 2 * span - m;
      posn = (mn <= span) ? mn : 2 * span - mn;
      e.count = 4'(s.lo + pos);
      e.busy  = 1'b1;
      e.up    = last && (posn > pos);
      e.dn    = last && (posn < pos);
    end
    return e;
  endfunction

  function automatic exp_t expAt(scen_t s, int k);
    exp_t e;
    if (s.stopAt >= 0 && k > s.stopAt) begin
      e = baseAt(s, s.stopAt);
      e.busy = 1'b0;
      e.done = 1'b0;
      e.up   = 1'b0;
      e.dn   = 1'b0;
    end else begin
      e = baseAt(s, k);
      if (k == s.stopAt) begin
        e.up = 1'b0;
        e.dn = 1'b0;
      end
    end
    return e;
  endfunction

  function automatic exp_t idleExp(logic [3:0] c, bit e_err);
    exp_t e;
    e = '{count: c, busy: 1'b0, done: 1'b0, err: e_err, up: 1'b0, dn: 1'b0};
    return e;
  endfunction

  task automatic applyStimulus(input bit st, input bit sp, input bit pp,
                               input int l, input int h, input int d, input exp_t e);
    start    = st;
    stop     = sp;
    pingpong = pp;
    lo       = 4'(l);
    hi       = 4'(h);
    dwell    = 4'(d);
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string tag, input int k);
    exp_t e;
    #2;
    e = sbq.pop_front();
    chk({tag, ".count"},     k, int'(count),     int'(e.count));
    chk({tag, ".busy"},      k, int'(busy),      int'(e.busy));
    chk({tag, ".done"},      k, int'(done),      int'(e.done));
    chk({tag, ".err"},       k, int'(err),       int'(e.err));
    chk({tag, ".step_up"},   k, int'(step_up),   int'(e.up));
    chk({tag, ".step_down"}, k, int'(step_down), int'(e.dn));
    if (done) doneSeen++;
    lastDutCount = int'(count);
    @(posedge clk);
    #1;
  endtask

  task automatic runSweep(input int idx, input scen_t s, input scen_t nxt, input bit skipStart);
    exp_t  e;
    string tag;
    tag = $sformatf("s%0d", idx);
    doneSeen = 0;
    if (!skipStart) begin
      applyStimulus(1'b1, 1'b0, s.pp, s.lo, s.hi, s.dwell, idleExp(lastCount, 1'b0));
      checkOutput({tag, ".start"}, -1);
    end
    for (int k = 0; k < s.cycles; k++) begin
      e = expAt(s, k);
      if (k == s.pokeAt)
        applyStimulus(1'b1, k == s.stopAt, 1'b1, 9, 12, 0, e);
      else if (s.chain && k == s.cycles - 1)
        applyStimulus(1'b1, 1'b0, nxt.pp, nxt.lo, nxt.hi, nxt.dwell, e);
      else
        applyStimulus(1'b0, k == s.stopAt, 1'($urandom), int'($urandom_range(15)),
                      int'($urandom_range(15)), int'($urandom_range(15)), e);
      checkOutput(tag, k);
      lastCount = e.count;
    end
    start = 1'b0;
    stop  = 1'b0;
    chk({tag, ".final_count"}, idx, lastDutCount, s.expFinal);
    chk({tag, ".done_pulses"}, idx, doneSeen, s.expDones);
  endtask

  initial begin
    exp_t e;
    //          pp  lo  hi  dw cyc stop poke chain rst final dones
    tbl[0] = '{1'b0, 2,  5,  0,  5, -1, -1, 1'b0, 1'b0,  5, 1};
    tbl[1] = '{1'b1, 1,  3,  1,  9,  6, -1, 1'b0, 1'b0,  2, 0};
    tbl[2] = '{1'b0, 0, 15,  0, 17, -1, -1, 1'b1, 1'b0, 15, 1};
    tbl[3] = '{1'b0, 3,  4,  2,  7, -1,  2, 1'b0, 1'b0,  4, 1};
    tbl[4] = '{1'b1, 7,  7,  0, 22, 20, -1, 1'b0, 1'b0,  7, 0};
    tbl[5] = '{1'b0, 7,  7,  3,  5, -1, -1, 1'b0, 1'b0,  7, 1};
    tbl[6] = '{1'b0, 4, 10,  1,  3,  1, -1, 1'b0, 1'b0,  4, 0};
    tbl[7] = '{1'b1, 13, 15, 0, 10,  8, -1, 1'b0, 1'b0, 13, 0};
    tbl[8] = '{1'b0, 2,  9,  3, 10, -1, -1, 1'b0, 1'b1,  4, 0};
    tbl[9] = '{1'b0, 0,  2,  1,  7, -1, -1, 1'b0, 1'b0,  2, 1};

    reset = 1'b1;
    start = 1'b0; stop = 1'b0; pingpong = 1'b0;
    lo = 4'd0; hi = 4'd0; dwell = 4'd0;
    doneSeen = 0;
    lastCount = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, idleExp(4'd0, 1'b0));
    checkOutput("reset", -1);
    reset = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b1, 9, 4, 2, idleExp(4'd0, 1'b0));
    checkOutput("err.start", 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, idleExp(4'd0, 1'b1));
    checkOutput("err.pulse", 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, idleExp(4'd0, 1'b0));
    checkOutput("err.clear", 2);

    for (int i = 0; i < 10; i++) begin
      runSweep(i, tbl[i], tbl[(i < 9) ? i + 1 : i], (i > 0) && tbl[(i > 0) ? i - 1 : 0].chain);
      if (tbl[i].resetAfter) begin
        // Reset lands mid-hold: the timer has already counted part of the dwell.
        e = expAt(tbl[i], tbl[i].cycles);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, e);
        reset = 1'b1;
        checkOutput("midreset.before", tbl[i].cycles);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, idleExp(4'd0, 1'b0));
        checkOutput("midreset.after", 0);
        lastCount = 4'd0;
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sweep_counter_ctrl.md
# sweep_counter_ctrl

Sweep controller for the 4-bit up/down counter datapath. It accepts a start command with a lower bound, an upper bound and a per-value dwell time. It then sequences the counter through lo→hi once (single mode) or back and forth between lo and hi until stopped (ping-pong mode). It owns an internal loadable up/down counter and exposes the count, the step strobes and the busy/done handshake to the surrounding test-pattern and sequencing logic.

## Interface
- WIDTH, 4, counter width
- DWELL_W, 4, dwell timer width
- clk  in  1  single clock; all state changes on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- start  in  1  launch a sweep; sampled only in IDLE
- stop  in  1  abort a running sweep; ignored in IDLE
- pingpong  in  1  0 = single sweep, 1 = continuous ping-pong; latched at start
- lo  in  WIDTH  lower bound; latched at start
- hi  in  WIDTH  upper bound; latched at start
- dwell  in  DWELL_W  extra cycles each value is held; latched at start
- count  out  WIDTH  current counter value
- step_up  out  1  counter increments at the next edge (combinational)
- step_down  out  1  counter decrements at the next edge (combinational)
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse on completion of a single sweep
- err  out  1  one-cycle pulse: start rejected because lo > hi

## Operation
- States: IDLE, UP, DOWN. Enum in package. DONE is not a state; done is a registered pulse.
- IDLE + start, lo ≤ hi:
  - latch lo/hi/dwell/pingpong; count ← lo; timer ← dwell; state ← UP; busy ← 1.
- IDLE + start, lo > hi:
  - err ← 1 for one cycle; state, count and latches unchanged.
- UP/DOWN, timer ≠ 0: timer decrements; no step.
- UP, timer == 0, count < hi_l: step_up = 1; count+1; timer ← dwell_l.
- UP, timer == 0, count == hi_l:
  - single mode: state ← IDLE, busy ← 0, done ← 1; count holds hi.
  - ping-pong, lo_l < hi_l: state ← DOWN, step_down = 1, count−1, timer ← dwell_l.
  - ping-pong, lo_l == hi_l: stay UP, no step, timer ← dwell_l; count stays constant until stop.
- DOWN, timer == 0: count > lo_l → step_down; count == lo_l → state ← UP, step_up, count+1, timer ← dwell_l.
- Each value is visible for dwell+1 cycles. Endpoints are not repeated at turnaround.
- stop while busy: next edge state ← IDLE, busy ← 0, no step, no done, count holds. Stop beats a step in the same cycle.
- start while busy is ignored. Inputs lo/hi/dwell/pingpong are don't-care outside the start cycle.
- step_up and step_down are never both 1. Count never leaves [lo_l, hi_l] while busy; no wrap-around is ever issued.
- Reset (any state, mid-sweep included): IDLE, count = 0, timer = 0, latches = 0, busy = done = err = 0, step strobes 0.

## Timing
- Start sampled at edge E0 → count = lo, busy = 1 from E0.
- Each value occupies dwell+1 cycles. A step strobe is high in the last cycle of a value; count changes at the following edge.
- Single sweep latency from start edge to done: (hi−lo+1)·(dwell+1) cycles. done and busy = 0 are visible together in that cycle.
- done and err: registered, exactly one cycle high.
- A new start is accepted in the cycle done is high, since the state is already IDLE.
- stop → busy low after one edge.

## Structure
- Package sweep_ctrl_pkg holds:
  - state enum {IDLE, UP, DOWN}
  - WIDTH and DWELL_W default constants
- Sub-module updown_core: WIDTH-bit counter with sync reset, load (value), inc, dec. inc and dec are mutually exclusive; load has priority.
- Top level holds the FSM, the dwell timer, the bound/mode latches and the pulse registers.

## Test plan
- Single sweep, lo = 2, hi = 5, dwell = 0 → count 2, 3, 4, 5 on consecutive cycles; done pulses once 4 cycles after start with count = 5 and busy = 0.
- Ping-pong, lo = 1, hi = 3, dwell = 1 → each value held 2 cycles: 1, 2, 3, 2, 1, 2, …; stop asserted mid-hold → busy = 0 next cycle, count frozen, no done.
- Bounds: lo = 0, hi = 15, dwell = 0, single → reaches 15 and stops; count never wraps to 0. start with lo = 9, hi = 4 → err for 1 cycle, busy stays 0.
- lo = hi = 7, ping-pong → count stays 7 with no step strobes for 20 cycles; stop returns to IDLE. Single mode → done after dwell+1 cycles.
- Simultaneous events:
  - stop in the same cycle as step_up → no increment.
  - start while busy → ignored.
  - start in the done cycle → new sweep begins.
- Reset mid-sweep (count = 4, dwell timer partially elapsed) → next cycle count = 0, busy = done = err = 0. The first start afterwards behaves as from power-up.
